// File: rtl/wb_chip_select_pkg.sv
// Shared Wishbone data-bus constants: peripheral base values and decode-field position.
package wb_chip_select_pkg;

  localparam int unsigned BUS_AW  = 32;
  localparam int unsigned DEC_MSB = 31;
  localparam int unsigned DEC_LSB = 24;
  localparam int unsigned DEC_W   = DEC_MSB - DEC_LSB + 1;

  // Base values must stay unique; overlaps are not detected by the decoders.
  localparam logic [DEC_W-1:0] DMA_BASE   = 8'h60;
  localparam logic [DEC_W-1:0] UART_BASE  = 8'h61;
  localparam logic [DEC_W-1:0] TIMER_BASE = 8'h62;

  function automatic logic [DEC_W-1:0] dec_field(input logic [BUS_AW-1:0] bus_addr);
    return bus_addr[DEC_MSB:DEC_LSB];
  endfunction

endpackage

// File: rtl/wb_chip_select.sv
// Per-peripheral address decoder: combinational select plus a registered single-cycle ack.
module wb_chip_select
  import wb_chip_select_pkg::*;
#(
  parameter logic [31:0] ADDR  = '0,
  parameter int unsigned WIDTH = DEC_W
) (
  input  logic             wb_ck,
  input  logic             wb_rst,
  input  logic [WIDTH-1:0] addr,
  input  logic             wb_cyc,
  output logic             cyc,
  output logic             ack
);

  // Base truncated or zero-extended to the decoded field width.
  localparam logic [WIDTH-1:0] BASE = WIDTH'(ADDR);

  logic match;
  logic ack_q;
  logic ack_d;

  assign match = (addr == BASE);
  assign cyc   = wb_cyc & match & wb_rst;

  // Suppress a second ack on the cycle right after one was issued.
  always_comb begin
    ack_d = 1'b0;
    ack_d = cyc & ~ack_q;
  end

  always_ff @(posedge wb_ck) begin
    if (!wb_rst) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign ack = ack_q;

endmodule

// File: tb/tb_wb_chip_select.sv
// Randomized and directed checks of two decoder instances (8-bit DMA base, 4-bit field at 4'hA).
module tb_wb_chip_select;
  import wb_chip_select_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wcyc;
  logic [31:0] bus_addr;
  logic [7:0]  addr8;
  logic [3:0]  addr4;
  logic        cyc8, ack8, cyc4, ack4;

  int errors = 0;
  int checks = 0;

  // Reference: did the edge just passed complete an access?
  bit m_done8, m_done4;

  always #5 clk = ~clk;

  assign addr8 = dec_field(bus_addr);

  wb_chip_select #(.ADDR(32'(DMA_BASE)), .WIDTH(DEC_W)) dut8 (
    .wb_ck (clk), .wb_rst(rst_n), .addr(addr8), .wb_cyc(wcyc), .cyc(cyc8), .ack(ack8)
  );

  wb_chip_select #(.ADDR(32'hA), .WIDTH(4)) dut4 (
    .wb_ck (clk), .wb_rst(rst_n), .addr(addr4), .wb_cyc(wcyc), .cyc(cyc4), .ack(ack4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit sel8(input bit r, input bit c, input logic [31:0] a);
    return r && c && (a[31:24] == 8'h60);
  endfunction

  function automatic bit sel4(input bit r, input bit c, input logic [3:0] a);
    return r && c && (a == 4'hA);
  endfunction

  // An access completes at an edge when selected, unless the previous edge already completed one.
  task automatic advance(input bit s8, input bit s4);
    @(posedge clk);
    m_done8 = s8 && !m_done8;
    m_done4 = s4 && !m_done4;
    #1;
  endtask

  task automatic step(input bit r, input bit c, input logic [31:0] ba, input logic [3:0] a4);
    bit s8, s4;
    rst_n = r; wcyc = c; bus_addr = ba; addr4 = a4;
    #2;
    s8 = sel8(r, c, ba);
    s4 = sel4(r, c, a4);
    check_eq("cyc8", 32'(cyc8), 32'(s8));
    check_eq("ack8", 32'(ack8), 32'(m_done8));
    check_eq("cyc4", 32'(cyc4), 32'(s4));
    check_eq("ack4", 32'(ack4), 32'(m_done4));
    advance(s8, s4);
  endtask

  // Strobe raised briefly mid-cycle and dropped before the edge.
  task automatic abort_step(input logic [31:0] ba, input logic [3:0] a4);
    rst_n = 1'b1; wcyc = 1'b1; bus_addr = ba; addr4 = a4;
    #1;
    check_eq("abort_cyc8_hi", 32'(cyc8), 32'(sel8(1'b1, 1'b1, ba)));
    check_eq("abort_cyc4_hi", 32'(cyc4), 32'(sel4(1'b1, 1'b1, a4)));
    wcyc = 1'b0;
    #1;
    check_eq("abort_cyc8_lo", 32'(cyc8), 32'd0);
    check_eq("abort_ack8", 32'(ack8), 32'(m_done8));
    advance(1'b0, 1'b0);
  endtask

  function automatic logic [31:0] hit8();
    return {8'h60, 24'($urandom)};
  endfunction

  function automatic logic [31:0] miss8();
    return {8'h61, 24'($urandom)};
  endfunction

  initial begin
    rst_n = 1'b0; wcyc = 1'b1; bus_addr = hit8(); addr4 = 4'hA;
    @(posedge clk); #1;
    m_done8 = 1'b0; m_done4 = 1'b0;

    // Reset held with a matching strobe, then released.
    repeat (3) step(1'b0, 1'b1, hit8(), 4'hA);
    step(1'b1, 1'b1, hit8(), 4'hA);
    check_eq("rel_ack8", 32'(ack8), 32'd1);
    step(1'b1, 1'b1, hit8(), 4'hA);
    step(1'b1, 1'b0, hit8(), 4'hA);

    // Single two-cycle access.
    step(1'b1, 1'b1, hit8(), 4'hA);
    step(1'b1, 1'b1, hit8(), 4'hA);
    step(1'b1, 1'b0, hit8(), 4'hA);

    // Non-matching address.
    repeat (5) step(1'b1, 1'b1, miss8(), 4'hB);
    step(1'b1, 1'b0, miss8(), 4'hB);

    // Held strobe gives ack 0,1,0,1,...
    repeat (6) step(1'b1, 1'b1, hit8(), 4'hA);
    step(1'b1, 1'b0, hit8(), 4'hA);
    step(1'b1, 1'b0, hit8(), 4'hA);

    // Abort, then reset during the ack cycle.
    abort_step(hit8(), 4'hA);
    step(1'b1, 1'b0, hit8(), 4'hA);
    step(1'b1, 1'b1, hit8(), 4'hA);
    step(1'b0, 1'b1, hit8(), 4'hA);
    check_eq("rst_ack_cyc8", 32'(cyc8), 32'd0);
    step(1'b1, 1'b0, hit8(), 4'hA);

    // Address moves away during the ack cycle.
    step(1'b1, 1'b1, hit8(), 4'hA);
    step(1'b1, 1'b1, miss8(), 4'hB);
    step(1'b1, 1'b1, miss8(), 4'hB);

    // Back-to-back accesses with one idle cycle after each ack.
    repeat (4) begin
      step(1'b1, 1'b1, hit8(), 4'hA);
      step(1'b1, 1'b1, hit8(), 4'hA);
      step(1'b1, 1'b0, hit8(), 4'hA);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ba;
      logic [3:0]  a4;
      bit r, c;
      r  = ($urandom_range(15) != 0);
      c  = ($urandom_range(3) != 0);
      ba = ($urandom_range(1) != 0) ? hit8() : 32'($urandom);
      a4 = ($urandom_range(1) != 0) ? 4'hA : 4'($urandom);
      step(r, c, ba, a4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
